// File: rtl/ov_pkg.sv
// Shared definitions for the OV7670 capture path:
// reader states, pixel byte order and default resolution.
package ov_pkg;

    typedef enum logic [3:0] {
        RD_IDLE,
        RD_RRST_HI,
        RD_RRST_LO,
        RD_B0_HI,
        RD_B0_LO,
        RD_B1_HI,
        RD_B1_LO,
        RD_HOLD,
        RD_DRAIN,
        RD_WAIT_CLR
    } rd_state_e;

    localparam bit FIRST_BYTE_MSB = 1'b1;
    localparam int BYTES_PER_PIXEL = 2;

    localparam int H_ACTIVE_DEF = 320;
    localparam int V_ACTIVE_DEF = 240;
    localparam int RRST_PULSES_DEF = 2;

endpackage

// File: rtl/ov_fifo_reader.sv
// Reads a stored frame out of the AL422 FIFO and streams
// RGB565 pixels with valid/ready flow control.
module ov_fifo_reader
    import ov_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int RRST_PULSES = RRST_PULSES_DEF
) (
    input  logic        clk_24MHz,
    input  logic        rst,
    input  logic        new_frame,
    output logic        frame_read,
    output logic        fifo_rrst,
    output logic        fifo_oe,
    output logic        fifo_rclk,
    input  logic [7:0]  fifo_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        busy
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int RW = (RRST_PULSES > 1) ? $clog2(RRST_PULSES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RRST_PULSES - 1);

    rd_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        frame_read_q, frame_read_d;
    logic        rrst_q, rrst_d;
    logic        oe_q, oe_d;
    logic        rclk_q, rclk_d;
    logic [15:0] pdata_q, pdata_d;
    logic        pvalid_q, pvalid_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        out_free;
    logic        last_pix;

    assign out_free = !pvalid_q || pix_ready;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        frame_read_d = frame_read_q;
        rrst_d       = rrst_q;
        oe_d         = oe_q;
        rclk_d       = rclk_q;
        pdata_d      = pdata_q;
        pvalid_d     = pvalid_q;
        sof_d        = sof_q;
        eol_d        = eol_q;

        if (pvalid_q && pix_ready) begin
            pvalid_d = 1'b0;
        end

        unique case (state_q)
            RD_IDLE: begin
                if (new_frame) begin
                    frame_read_d = 1'b0;
                    rrst_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = RD_RRST_HI;
                end
            end
            RD_RRST_HI: begin
                rclk_d  = 1'b1;
                state_d = RD_RRST_LO;
            end
            RD_RRST_LO: begin
                rclk_d = 1'b0;
                if (cnt_q == R_LAST) begin
                    rrst_d  = 1'b1;
                    oe_d    = 1'b0;
                    state_d = RD_B0_HI;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RD_RRST_HI;
                end
            end
            RD_B0_HI: begin
                rclk_d  = 1'b1;
                state_d = RD_B0_LO;
            end
            RD_B0_LO: begin
                rclk_d  = 1'b0;
                hi_d    = fifo_data;
                state_d = RD_B1_HI;
            end
            RD_B1_HI: begin
                // Second byte is not clocked until the previous pixel is gone.
                if (out_free) begin
                    rclk_d  = 1'b1;
                    state_d = RD_B1_LO;
                end
            end
            RD_B1_LO: begin
                rclk_d   = 1'b0;
                pdata_d  = FIRST_BYTE_MSB ? {hi_q, fifo_data}
                                          : {fifo_data, hi_q};
                pvalid_d = 1'b1;
                sof_d    = (x_q == '0) && (y_q == '0);
                eol_d    = (x_q == X_LAST);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (last_pix) begin
                    state_d = RD_DRAIN;
                end else if (pix_ready) begin
                    state_d = RD_B0_HI;
                end else begin
                    state_d = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (pix_ready) begin
                    state_d = RD_B0_HI;
                end
            end
            RD_DRAIN: begin
                if (out_free) begin
                    oe_d         = 1'b1;
                    frame_read_d = 1'b1;
                    state_d      = RD_WAIT_CLR;
                end
            end
            RD_WAIT_CLR: begin
                // new_frame is still the stale level from the store side.
                if (!new_frame) begin
                    state_d = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_24MHz) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            hi_q         <= '0;
            frame_read_q <= 1'b1;
            rrst_q       <= 1'b1;
            oe_q         <= 1'b1;
            rclk_q       <= 1'b0;
            pdata_q      <= '0;
            pvalid_q     <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            frame_read_q <= frame_read_d;
            rrst_q       <= rrst_d;
            oe_q         <= oe_d;
            rclk_q       <= rclk_d;
            pdata_q      <= pdata_d;
            pvalid_q     <= pvalid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
        end
    end

    assign frame_read = frame_read_q;
    assign fifo_rrst  = rrst_q;
    assign fifo_oe    = oe_q;
    assign fifo_rclk  = rclk_q;
    assign pix_data   = pdata_q;
    assign pix_valid  = pvalid_q;
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign busy       = (state_q != RD_IDLE);

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Bench for ov_fifo_reader on a 4x2 frame with an AL422 read-side
// model that returns bytes 0x00,0x01,... after each read reset.
module tb_ov_fifo_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_frame;
    logic        frame_read;
    logic        fifo_rrst;
    logic        fifo_oe;
    logic        fifo_rclk;
    logic [7:0]  fifo_data = 8'h00;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof;
    logic        pix_eol;
    logic        busy;

    ov_fifo_reader #(.H_ACTIVE(4), .V_ACTIVE(2), .RRST_PULSES(2)) dut (
        .clk_24MHz (clk),
        .rst       (rst),
        .new_frame (new_frame),
        .frame_read(frame_read),
        .fifo_rrst (fifo_rrst),
        .fifo_oe   (fifo_oe),
        .fifo_rclk (fifo_rclk),
        .fifo_data (fifo_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .busy      (busy)
    );

    always #21 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // AL422 read side
    int rd_ptr = 0;
    int data_rises = 0;
    int rrst_rises = 0;
    always @(posedge fifo_rclk) begin
        if (!fifo_rrst) begin
            rd_ptr = 0;
            rrst_rises++;
        end else begin
            fifo_data = 8'(rd_ptr);
            rd_ptr++;
            data_rises++;
        end
    end

    // consumer ready: forced level or 30% random stalls
    logic rdy_force = 1'b1;
    logic rnd_en = 1'b0;
    always @(posedge clk) begin
        #1;
        pix_ready = rnd_en ? ($urandom_range(0, 9) >= 3) : rdy_force;
    end

    // accepted-pixel recorder and hold-stability watcher
    logic [15:0] mon_data [0:255];
    logic        mon_sof  [0:255];
    logic        mon_eol  [0:255];
    int          mon_cyc  [0:255];
    int          nacc = 0;
    int          stab_err = 0;
    logic        hold_q = 1'b0;
    logic [17:0] hold_v = '0;
    always @(negedge clk) begin
        if (!rst && hold_q &&
            (!pix_valid || {pix_data, pix_sof, pix_eol} !== hold_v))
            stab_err++;
        hold_q = !rst && pix_valid && !pix_ready;
        hold_v = {pix_data, pix_sof, pix_eol};
        if (!rst && pix_valid && pix_ready && nacc < 256) begin
            mon_data[nacc] = pix_data;
            mon_sof[nacc]  = pix_sof;
            mon_eol[nacc]  = pix_eol;
            mon_cyc[nacc]  = cyc;
            nacc++;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } pix_vec_t;

    pix_vec_t exp_tab [0:7];

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fr(input logic lvl, input int lim,
                           input string name);
        int n;
        n = 0;
        while (frame_read !== lvl && n < lim) begin
            tick();
            n++;
        end
        chk(name, 32'(frame_read), 32'(lvl));
    endtask

    task automatic check_frame(input int base, input string tag);
        chk({tag, "_count"}, 32'(nacc - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_data%0d", tag, i),
                32'(mon_data[base+i]), 32'(exp_tab[i].data));
            chk($sformatf("%s_sof%0d", tag, i),
                32'(mon_sof[base+i]), 32'(exp_tab[i].sof));
            chk($sformatf("%s_eol%0d", tag, i),
                32'(mon_eol[base+i]), 32'(exp_tab[i].eol));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk(name,
            {8'h0, frame_read, fifo_rrst, fifo_oe, fifo_rclk,
             pix_valid, pix_sof, pix_eol, busy, pix_data},
            {8'h0, 8'b1110_0000, 16'h0000});
    endtask

    task automatic start_and_first(input string tag);
        int n;
        int b_rr;
        b_rr = rrst_rises;
        new_frame = 1'b1;
        tick();
        chk({tag, "_fr_fall"}, 32'(frame_read), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!pix_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_first_data"}, 32'(pix_data), 32'h0001);
        chk({tag, "_first_sof"}, 32'(pix_sof), 32'd1);
        chk({tag, "_rrst_pulses"}, 32'(rrst_rises - b_rr), 32'd2);
    endtask

    int b_acc;
    int b_dr;
    int n;

    initial begin
        exp_tab[0] = '{16'h0001, 1'b1, 1'b0};
        exp_tab[1] = '{16'h0203, 1'b0, 1'b0};
        exp_tab[2] = '{16'h0405, 1'b0, 1'b0};
        exp_tab[3] = '{16'h0607, 1'b0, 1'b1};
        exp_tab[4] = '{16'h0809, 1'b0, 1'b0};
        exp_tab[5] = '{16'h0a0b, 1'b0, 1'b0};
        exp_tab[6] = '{16'h0c0d, 1'b0, 1'b0};
        exp_tab[7] = '{16'h0e0f, 1'b0, 1'b1};

        rst = 1'b1;
        new_frame = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        tick();
        check_idle_outputs("idle_outputs");

        // frame 1: no backpressure
        b_acc = nacc;
        b_dr = data_rises;
        start_and_first("f1");
        wait_fr(1'b1, 200, "f1_fr_rise");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f1_wait_clr_busy", 32'(busy), 32'd1);
            chk("f1_wait_clr_rrst", 32'(fifo_rrst), 32'd1);
            chk("f1_wait_clr_fr", 32'(frame_read), 32'd1);
        end
        new_frame = 1'b0;
        tick();
        chk("f1_back_idle", 32'(busy), 32'd0);
        tick();
        chk("f1_idle_rrst", 32'(fifo_rrst), 32'd1);
        chk("f1_oe_off", 32'(fifo_oe), 32'd1);
        check_frame(b_acc, "f1");
        chk("f1_spacing", 32'(mon_cyc[b_acc+7] - mon_cyc[b_acc]), 32'd28);
        chk("f1_data_rises", 32'(data_rises - b_dr), 32'd16);

        // frame 2: random stalls
        rnd_en = 1'b1;
        b_acc = nacc;
        b_dr = data_rises;
        new_frame = 1'b1;
        wait_fr(1'b0, 10, "f2_fr_fall");
        wait_fr(1'b1, 2000, "f2_fr_rise");
        tick();
        new_frame = 1'b0;
        tick();
        tick();
        rnd_en = 1'b0;
        chk("f2_back_idle", 32'(busy), 32'd0);
        check_frame(b_acc, "f2");
        chk("f2_data_rises", 32'(data_rises - b_dr), 32'd16);
        chk("f2_hold_stable", 32'(stab_err), 32'd0);

        // frame 3: reset in the middle of the frame
        tick();
        b_acc = nacc;
        new_frame = 1'b1;
        n = 0;
        while (nacc - b_acc < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("f3_reached_pix5", 32'(nacc - b_acc >= 5), 32'd1);
        rst = 1'b1;
        new_frame = 1'b0;
        tick();
        check_idle_outputs("f3_midrst_outputs");
        tick();
        rst = 1'b0;
        tick();

        // frame 4: restart after reset
        b_acc = nacc;
        b_dr = data_rises;
        start_and_first("f4");
        wait_fr(1'b1, 200, "f4_fr_rise");
        tick();
        new_frame = 1'b0;
        tick();
        tick();
        chk("f4_back_idle", 32'(busy), 32'd0);
        check_frame(b_acc, "f4");
        chk("f4_data_rises", 32'(data_rises - b_dr), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
